// File: rtl/cla_iter.sv
// cla_iter: iterative add/sub/and/or unit, add/sub computed CHUNK bits per cycle with in-slice carry lookahead
// Ports: clock/reset_n (async active-low); in_valid/in_ready + op/a/b/cin request;
// abort cancels in-flight work; out_valid/out_ready handshake with result and cout/overflow/is_zero/is_neg.
module cla_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             is_zero,
  output logic             is_neg
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nxt;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic [1:0] op_r;
  logic cy, live, accept, last, arith;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] xs, ys, sum;
  logic [CHUNK:0] c;
  // Flat lookahead: each carry is the OR of every generate term propagated up to it.
  function automatic logic [CHUNK:0] carries(input logic [CHUNK-1:0] x, input logic [CHUNK-1:0] y, input logic ci);
    logic [CHUNK-1:0] g, p;
    logic [CHUNK:0] cc;
    logic t;
    g = x & y;
    p = x ^ y;
    cc[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      t = ci;
      for (int k = 0; k <= i; k++) t = t & p[k];
      cc[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        cc[i+1] = cc[i+1] | t;
      end
    end
    return cc;
  endfunction
  always_comb begin
    xs = a_r[idx*CHUNK +: CHUNK];
    ys = b_r[idx*CHUNK +: CHUNK];
    c = carries(xs, ys, cy);
    sum = xs ^ ys ^ c[CHUNK-1:0];
    arith = ~op_r[1];
    last = ~arith | (idx == IW'(NCH - 1));
    accept = in_ready & in_valid & ~abort;
    nxt = (abort && st != IDLE) ? IDLE :
          st == IDLE ? (accept ? RUN : IDLE) :
          st == RUN  ? (last ? DONE : RUN) :
          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      live <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      res <= '0;
      op_r <= 2'b00;
      cy <= 1'b0;
      idx <= '0;
    end else begin
      st <= nxt;
      live <= 1'b1;
      if (accept) begin
        a_r <= a;
        b_r <= op == 2'b01 ? ~b : b;
        op_r <= op;
        cy <= (op == 2'b01) | ((op == 2'b00) & cin);
        idx <= '0;
        res <= '0;
      end else if (st == RUN && !abort) begin
        if (arith) begin
          res[idx*CHUNK +: CHUNK] <= sum;
          cy <= c[CHUNK];
          idx <= idx + 1'b1;
        end else begin
          res <= op_r[0] ? (a_r | b_r) : (a_r & b_r);
          cy <= 1'b0;
        end
      end
    end
  end
  assign out_valid = st == DONE;
  assign in_ready = live & (st == IDLE);
  assign result = out_valid ? res : '0;
  assign cout = out_valid & arith & cy;
  assign overflow = out_valid & arith & (a_r[WIDTH-1] == b_r[WIDTH-1]) & (res[WIDTH-1] != a_r[WIDTH-1]);
  assign is_zero = out_valid & ~|res;
  assign is_neg = out_valid & res[WIDTH-1];
endmodule

// File: tb/tb_cla_iter.sv
// tb_cla_iter: directed checks of cla_iter arithmetic, latency, backpressure, abort and reset
module tb_cla_iter;
  logic clock, reset_n, in_valid, in_ready, cin, abort, out_valid, out_ready;
  logic cout, overflow, is_zero, is_neg;
  logic [1:0] op;
  logic [31:0] a, b, result;
  int total = 0;
  int bad = 0;
  cla_iter dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .overflow(overflow),
    .is_zero(is_zero), .is_neg(is_neg)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input int lat, input logic [31:0] er,
                       input logic ec, input logic ev, input logic ez, input logic en);
    int n;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk32({tag, ".latency"}, n, lat);
    chk32({tag, ".result"}, result, er);
    chk1({tag, ".cout"}, cout, ec);
    chk1({tag, ".overflow"}, overflow, ev);
    chk1({tag, ".is_zero"}, is_zero, ez);
    chk1({tag, ".is_neg"}, is_neg, en);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk1({tag, ".out_valid_clr"}, out_valid, 1'b0);
    chk1({tag, ".in_ready_back"}, in_ready, 1'b1);
    chk32({tag, ".result_idle"}, result, 32'h0);
  endtask
  task automatic quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick;
      chk1(tag, out_valid, 1'b0);
    end
  endtask
  initial begin
    int n;
    reset_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick;
    tick;
    chk1("rst.in_ready", in_ready, 1'b0);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk32("rst.result", result, 32'h0);
    chk1("rst.flags", cout | overflow | is_zero | is_neg, 1'b0);
    reset_n = 1'b1;
    #1;
    chk1("rel.in_ready_before_edge", in_ready, 1'b0);
    tick;
    chk1("rel.in_ready_first_edge", in_ready, 1'b1);
    do_op("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("add_cin", 2'b00, 32'h12345678, 32'h11111111, 1'b1, 4, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_mix", 2'b00, 32'h80000000, 32'h80000000, 1'b0, 4, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    do_op("sub_eq", 2'b01, 32'd5, 32'd5, 1'b0, 4, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sub_ovf", 2'b01, 32'h80000000, 32'd1, 1'b0, 4, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("sub_neg", 2'b01, 32'd3, 32'd5, 1'b1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("and", 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("or", 2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("and_zero", 2'b10, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
    op = 2'b00; a = 32'd1; b = 32'd2; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk32("bp.latency", n, 4);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk1("bp.out_valid_hold", out_valid, 1'b1);
      chk32("bp.result_hold", result, 32'd3);
      chk1("bp.flags_hold", {cout, overflow, is_zero, is_neg} == 4'b0000, 1'b1);
      chk1("bp.in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk1("bp.out_valid_clr", out_valid, 1'b0);
    chk1("bp.in_ready_back", in_ready, 1'b1);
    op = 2'b00; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk1("abort.in_run", in_ready, 1'b0);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk1("abort.out_valid", out_valid, 1'b0);
    chk1("abort.in_ready", in_ready, 1'b1);
    quiet("abort.no_valid", 6);
    do_op("after_abort", 2'b00, 32'd3, 32'd4, 1'b0, 4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; abort = 1'b1; a = 32'd9; b = 32'd9;
    tick;
    in_valid = 1'b0; abort = 1'b0;
    chk1("idle_abort.no_accept", in_ready, 1'b1);
    quiet("idle_abort.no_valid", 6);
    op = 2'b10; a = 32'hFFFF0000; b = 32'h0FF00000; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk1("done_abort.valid", out_valid, 1'b1);
    abort = 1'b1; out_ready = 1'b1;
    tick;
    abort = 1'b0; out_ready = 1'b0;
    chk1("done_abort.out_valid", out_valid, 1'b0);
    chk1("done_abort.in_ready", in_ready, 1'b1);
    op = 2'b00; a = 32'd100; b = 32'd200; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    reset_n = 1'b0;
    #2;
    chk1("rst_run.out_valid", out_valid, 1'b0);
    chk1("rst_run.in_ready", in_ready, 1'b0);
    reset_n = 1'b1;
    tick;
    chk1("rst_run.in_ready_edge", in_ready, 1'b1);
    quiet("rst_run.no_valid", 6);
    do_op("after_reset", 2'b00, 32'd3, 32'd4, 1'b0, 4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
